block_ram: RTL and testbench

BLOCK_RAM -- requirements
Module: block_ram

---
 rtl/block_ram.sv | 64 ++++++
 tb/tb_block_ram.sv | 119 +++++++++++
 2 files changed

// File: rtl/block_ram.sv
// Simple dual-port block RAM with one-cycle registered read, read-first collision
// behaviour, and a post-reset sweep that zeroes every word before user access opens.
module block_ram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 9,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] w_value,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] r_value,
   output logic                  init_done
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH-1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] clr_q, clr_d;
   logic                  init_done_q, init_done_d;
   logic [DATA_WIDTH-1:0] r_value_q, r_value_d;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  w_in_range, r_in_range;

   always_comb begin
      w_in_range  = ({1'b0, w_addr} < DEPTH_W);
      r_in_range  = ({1'b0, r_addr} < DEPTH_W);
      // The sweep owns the write port until the clear completes; user writes are dropped.
      wr_en       = init_done_q ? (w_en && w_in_range) : 1'b1;
      wr_addr     = init_done_q ? w_addr  : clr_q;
      wr_data     = init_done_q ? w_value : '0;
      clr_d       = init_done_q ? clr_q   : clr_q + 1'b1;
      init_done_d = init_done_q | (clr_q == LAST);
      r_value_d   = '0;
      if (init_done_q && r_in_range) r_value_d = mem_q[r_addr];
   end

   // Storage is never reset; only the sweep zeroes it.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_q       <= '0;
         init_done_q <= 1'b0;
         r_value_q   <= '0;
      end else begin
         clr_q       <= clr_d;
         init_done_q <= init_done_d;
         r_value_q   <= r_value_d;
      end
   end

   assign r_value   = r_value_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_block_ram.sv
// Directed + randomized checks of block_ram against an array model of the memory.
module tb_block_ram;

   localparam int AW = 10;
   localparam int DW = 9;
   localparam int D  = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          w_en = 1'b0;
   logic [AW-1:0] w_addr = '0;
   logic [DW-1:0] w_value = '0;
   logic [AW-1:0] r_addr = '0;
   logic [DW-1:0] r_value;
   logic          init_done;

   int vectors = 0;
   int miscompares = 0;
   int model [D];

   block_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_value(w_value),
      .r_addr(r_addr), .r_value(r_value), .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive after a negedge, let one posedge pass, check at the next negedge.
   task automatic cyc(input string tag, input logic we, input int wa, input int wv, input int ra);
      int exp;
      w_en = we; w_addr = AW'(wa); w_value = DW'(wv); r_addr = AW'(ra);
      @(negedge clk);
      exp = model[ra];
      if (we) model[wa] = wv & 'h1FF;
      check(tag, {23'b0, r_value}, exp);
      w_en = 1'b0;
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      while (!init_done && n < 2000) begin
         if (n < 5) begin w_en = 1'b1; w_addr = '0; w_value = 9'h1FF; end
         else w_en = 1'b0;
         @(negedge clk);
         n++;
         if (n == 100) check({tag, "_rd_zero"}, {23'b0, r_value}, 0);
      end
      w_en = 1'b0;
      check(tag, n, 1024);
      for (int i = 0; i < D; i++) model[i] = 0;
   endtask

   initial begin
      for (int i = 0; i < D; i++) model[i] = 0;
      #2 rst = 1'b1;
      #1 check("rst_rvalue", {23'b0, r_value}, 0);
      check("rst_init", {31'b0, init_done}, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      wait_init("sweep1");

      cyc("rd0_set", 0, 0, 0, 0);
      cyc("rd0", 0, 0, 0, 511);
      cyc("rd511", 0, 0, 0, 1023);
      cyc("rd1023", 0, 0, 0, 1023);

      cyc("wr7", 1, 7, 'h1A5, 0);
      cyc("rd7_set", 0, 0, 0, 7);
      cyc("rd7", 0, 0, 0, 7);

      cyc("wr3", 1, 3, 'h055, 0);
      cyc("coll_old", 1, 3, 'h0FF, 3);
      cyc("coll_new", 0, 0, 0, 3);

      cyc("diff_rw", 1, 9, 'h123, 7);
      cyc("diff_rd9", 0, 0, 0, 9);

      for (int i = 0; i < 400; i++)
         cyc("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 511),
             $urandom_range(0, 15));

      for (int a = 0; a < D; a++) cyc("seq_wr", 1, a, a, 0);
      for (int a = 0; a < D; a++) cyc("seq_rd", 0, 0, 0, a);
      cyc("seq_last", 0, 0, 0, 0);

      // Async reset between edges while reading 0x1A5.
      cyc("wr7b", 1, 7, 'h1A5, 7);
      cyc("rd7b", 0, 0, 0, 7);
      check("hold_1a5", {23'b0, r_value}, 'h1A5);
      #3 rst = 1'b1;
      #1 check("async_rvalue", {23'b0, r_value}, 0);
      check("async_init", {31'b0, init_done}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 500; i++) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("midsweep_init", {31'b0, init_done}, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_init("sweep2");

      cyc("post_rd7_set", 0, 0, 0, 7);
      cyc("post_rd7", 0, 0, 0, 0);
      cyc("post_rd0", 0, 0, 0, 1023);
      cyc("post_rd1023", 0, 0, 0, 1023);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
